// File: rtl/freq_div_ratio_updater.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : freq_div_ratio_updater
// Description : Accepts a new division ratio and hands it to the divider over
//               a 4-phase req/ack handshake with synchronised ack and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div_ratio_updater #(
    parameter int RESET_RATIO = 10,
    parameter int MIN_RATIO   = 2,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [9:0] cfg_ratio,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [9:0] ratio,
    output logic       ratio_upd_req,
    input  logic       ratio_upd_ack,
    output logic       busy,
    output logic       done,
    output logic       err_range,
    output logic       err_timeout
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    localparam logic [9:0] c_CNT_MAX      = 10'h3FF;
    localparam logic [9:0] c_RESET_RATIO  = 10'(RESET_RATIO);
    localparam logic [9:0] c_MIN_RATIO    = 10'(MIN_RATIO);
    // Timeout fires on the edge where the phase has lasted TIMEOUT cycles.
    localparam logic [9:0] c_TIMEOUT_LAST = (TIMEOUT > 1) ? 10'(TIMEOUT - 1) : 10'd0;
    // HOLD is entered one cycle after ack_s rises, so it lasts HOLD_CYC-1 cycles.
    localparam logic [9:0] c_HOLD_LAST    = (HOLD_CYC > 2) ? 10'(HOLD_CYC - 2) : 10'd0;

    logic [1:0] state_q,       state_d;
    logic [9:0] ratio_q,       ratio_d;
    logic       req_q,         req_d;
    logic [9:0] cnt_q,         cnt_d;
    logic [9:0] hold_cnt_q,    hold_cnt_d;
    logic       ack_meta_q,    ack_meta_d;
    logic       ack_s_q,       ack_s_d;
    logic       done_q,        done_d;
    logic       err_range_q,   err_range_d;
    logic       err_timeout_q, err_timeout_d;
    logic [9:0] w_cnt_inc;

    assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 10'd1;

    always_comb begin
        state_d       = state_q;
        ratio_d       = ratio_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        hold_cnt_d    = hold_cnt_q;
        ack_meta_d    = ratio_upd_ack;
        ack_s_d       = ack_meta_q;
        done_d        = 1'b0;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            c_IDLE: begin
                cnt_d = 10'd0;
                if (cfg_valid) begin
                    if (cfg_ratio >= c_MIN_RATIO) begin
                        ratio_d = cfg_ratio;
                        req_d   = 1'b1;
                        state_d = c_REQ;
                    end else begin
                        err_range_d = 1'b1;
                    end
                end
            end
            c_REQ: begin
                if (ack_s_q) begin
                    state_d    = c_HOLD;
                    cnt_d      = 10'd0;
                    hold_cnt_d = 10'd0;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    req_d         = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = c_RELEASE;
                    cnt_d         = 10'd0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            c_HOLD: begin
                if (hold_cnt_q == c_HOLD_LAST) begin
                    req_d   = 1'b0;
                    state_d = c_RELEASE;
                    cnt_d   = 10'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 10'd1;
                end
            end
            c_RELEASE: begin
                // A stuck-high ack re-arms the timeout rather than reissuing req.
                if (!ack_s_q) begin
                    done_d  = 1'b1;
                    state_d = c_IDLE;
                    cnt_d   = 10'd0;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = 10'd0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            default: begin
                state_d = c_IDLE;
                req_d   = 1'b0;
                cnt_d   = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q       <= c_IDLE;
            ratio_q       <= c_RESET_RATIO;
            req_q         <= 1'b0;
            cnt_q         <= 10'd0;
            hold_cnt_q    <= 10'd0;
            ack_meta_q    <= 1'b0;
            ack_s_q       <= 1'b0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ratio_q       <= ratio_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            ack_meta_q    <= ack_meta_d;
            ack_s_q       <= ack_s_d;
            done_q        <= done_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign cfg_ready     = (state_q == c_IDLE);
    assign busy          = (state_q != c_IDLE);
    assign ratio         = ratio_q;
    assign ratio_upd_req = req_q;
    assign done          = done_q;
    assign err_range     = err_range_q;
    assign err_timeout   = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_div_ratio_updater.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_freq_div_ratio_updater
// Description : Randomised handshake bench with a transaction-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_div_ratio_updater;

    localparam int RESET_RATIO = 10;
    localparam int MIN_RATIO   = 2;
    localparam int HOLD_CYC    = 2;
    localparam int TIMEOUT     = 1023;

    logic       clkin = 1'b0;
    logic       rst;
    logic [9:0] cfg_ratio;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] ratio;
    logic       ratio_upd_req;
    logic       ratio_upd_ack;
    logic       busy;
    logic       done;
    logic       err_range;
    logic       err_timeout;

    int n_total = 0;
    int n_bad   = 0;
    int exp_ratio;
    int glitches;
    int req_rises = 0, dones = 0;
    int exp_req_rises = 0, exp_dones = 0;
    logic req_prev = 1'b0;

    freq_div_ratio_updater #(
        .RESET_RATIO (RESET_RATIO),
        .MIN_RATIO   (MIN_RATIO),
        .HOLD_CYC    (HOLD_CYC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clkin         (clkin),
        .rst           (rst),
        .cfg_ratio     (cfg_ratio),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ratio         (ratio),
        .ratio_upd_req (ratio_upd_req),
        .ratio_upd_ack (ratio_upd_ack),
        .busy          (busy),
        .done          (done),
        .err_range     (err_range),
        .err_timeout   (err_timeout)
    );

    always #5 clkin = ~clkin;

    // Independent event counters: every req rise and every done pulse.
    always @(negedge clkin) begin
        req_prev <= ratio_upd_req;
        if (ratio_upd_req === 1'b1 && req_prev === 1'b0) req_rises <= req_rises + 1;
        if (done === 1'b1) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clkin);
    endtask

    // One cycle inside a handshake: ratio frozen, no pulses; optionally hammer cfg.
    task automatic tick_track(input bit hammer);
        logic [9:0] er;
        tick();
        if (hammer) cfg_ratio = 10'($urandom_range(0, 1023));
        er = exp_ratio[9:0];
        if (ratio !== er || done !== 1'b0 || err_range !== 1'b0 || err_timeout !== 1'b0)
            glitches++;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(cfg_ready), 1);
    endtask

    task automatic do_update(input int val, input int lat_rise, input int lat_fall, input bit hammer);
        int n;
        wait_ready();
        cfg_ratio = 10'(val);
        cfg_valid = 1'b1;
        tick();
        exp_ratio = val;
        exp_req_rises++;
        glitches = 0;
        chk("acc_ratio", 32'(ratio), val);
        chk("acc_req", 32'(ratio_upd_req), 1);
        chk("acc_busy", 32'(busy), 1);
        chk("acc_ready", 32'(cfg_ready), 0);
        if (!hammer) cfg_valid = 1'b0;
        for (int i = 0; i < lat_rise; i++) tick_track(hammer);
        ratio_upd_ack = 1'b1;
        n = 0;
        do begin
            tick_track(hammer);
            n++;
        end while (ratio_upd_req === 1'b1 && n < 200);
        // Two synchroniser stages, then req held HOLD_CYC cycles past ack_s rise.
        chk("req_hold", n, HOLD_CYC + 2);
        for (int i = 0; i < lat_fall; i++) tick_track(hammer);
        ratio_upd_ack = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            if (hammer) cfg_ratio = 10'($urandom_range(0, 1023));
            n++;
        end
        cfg_valid = 1'b0;
        exp_dones++;
        chk("done_lat", n, 3);
        chk("hs_glitches", glitches, 0);
        chk("done_ready", 32'(cfg_ready), 1);
        chk("done_ratio", 32'(ratio), val);
        tick();
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic do_bad(input int val);
        wait_ready();
        cfg_ratio = 10'(val);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("range_err", 32'(err_range), 1);
        chk("range_ratio", 32'(ratio), exp_ratio);
        chk("range_req", 32'(ratio_upd_req), 0);
        chk("range_ready", 32'(cfg_ready), 1);
        tick();
        chk("range_pulse", 32'(err_range), 0);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        cfg_valid     = 1'b0;
        cfg_ratio     = 10'd0;
        ratio_upd_ack = 1'b0;
        exp_ratio     = RESET_RATIO;
        repeat (3) tick();
        chk("rst_ratio", 32'(ratio), RESET_RATIO);
        chk("rst_req", 32'(ratio_upd_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_erange", 32'(err_range), 0);
        chk("rst_etimeout", 32'(err_timeout), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
        tick();

        do_update(25, 3, 4, 1'b0);
        do_bad(1);
        do_bad(0);
        do_update(MIN_RATIO, 0, 0, 1'b1);
        do_bad(MIN_RATIO - 1);

        // Ack never arrives: REQ times out, then done once ack_s is low.
        wait_ready();
        cfg_ratio = 10'd30;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        exp_ratio = 30;
        exp_req_rises++;
        n = 0;
        while (err_timeout !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("req_timeout", n, TIMEOUT);
        chk("req_timeout_req", 32'(ratio_upd_req), 0);
        tick();
        chk("req_timeout_done", 32'(done), 1);
        chk("req_timeout_ratio", 32'(ratio), 30);
        exp_dones++;

        // Ack stuck high after req drops: RELEASE times out and stays busy.
        wait_ready();
        cfg_ratio = 10'd33;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        exp_ratio = 33;
        exp_req_rises++;
        ratio_upd_ack = 1'b1;
        n = 0;
        while (ratio_upd_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("rel_req_hold", n, HOLD_CYC + 2);
        n = 0;
        while (err_timeout !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("rel_timeout", n, TIMEOUT);
        chk("rel_timeout_busy", 32'(busy), 1);
        chk("rel_timeout_req", 32'(ratio_upd_req), 0);
        ratio_upd_ack = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("rel_done_lat", n, 3);
        exp_dones++;

        // Reset while in HOLD.
        wait_ready();
        cfg_ratio = 10'd17;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        exp_ratio = 17;
        exp_req_rises++;
        ratio_upd_ack = 1'b1;
        repeat (3) tick();
        chk("hold_req", 32'(ratio_upd_req), 1);
        rst = 1'b1;
        tick();
        chk("hold_rst_req", 32'(ratio_upd_req), 0);
        chk("hold_rst_ratio", 32'(ratio), RESET_RATIO);
        chk("hold_rst_ready", 32'(cfg_ready), 1);
        exp_ratio = RESET_RATIO;
        ratio_upd_ack = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 10; i++)
            do_update(int'($urandom_range(40, 10)), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 12)), i[0]);

        repeat (3) tick();
        chk("req_count", req_rises, exp_req_rises);
        chk("done_count", dones, exp_dones);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
